// File: rtl/vga_timing_generator.sv
// Raster timing source: free-running pixel/line counters with combinational
// decodes for sync, active video, saturated coordinates and end-of-frame strobe.
module vga_timing_generator #(
  parameter int WIDTH   = 640,
  parameter int HEIGHT  = 480,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk25,
  input  logic       reset,
  output logic       screenEnd,
  output logic       active,
  output logic       hSync,
  output logic       vSync,
  output logic [9:0] x,
  output logic [8:0] y
);

  localparam logic [9:0] H_ACT     = 10'(WIDTH);
  localparam logic [9:0] H_SYNC_LO = 10'(WIDTH + H_FRONT);
  localparam logic [9:0] H_SYNC_HI = 10'(WIDTH + H_FRONT + H_SYNC);
  localparam logic [9:0] H_LAST    = 10'(WIDTH + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] V_ACT     = 10'(HEIGHT);
  localparam logic [9:0] V_SYNC_LO = 10'(HEIGHT + V_FRONT);
  localparam logic [9:0] V_SYNC_HI = 10'(HEIGHT + V_FRONT + V_SYNC);
  localparam logic [9:0] V_LAST    = 10'(HEIGHT + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] X_MAX     = 10'(WIDTH - 1);
  localparam logic [8:0] Y_MAX     = 9'(HEIGHT - 1);

  logic [9:0] h_count;
  logic [9:0] v_count;

  always_ff @(posedge clk25) begin
    if (reset) begin
      h_count <= '0;
      v_count <= '0;
    end else if (h_count == H_LAST) begin
      h_count <= '0;
      v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
    end else begin
      h_count <= h_count + 10'd1;
    end
  end

  // All outputs decode the counters directly, so they track the count with no pipeline delay.
  always_comb begin
    active    = (h_count < H_ACT) && (v_count < V_ACT);
    hSync     = !((h_count >= H_SYNC_LO) && (h_count < H_SYNC_HI));
    vSync     = !((v_count >= V_SYNC_LO) && (v_count < V_SYNC_HI));
    screenEnd = (h_count == 10'd0) && (v_count == V_ACT);
    x         = (h_count < H_ACT) ? h_count : X_MAX;
    y         = (v_count < V_ACT) ? v_count[8:0] : Y_MAX;
  end

endmodule

// File: tb/tb_vga_timing_generator.sv
// Directed bench: full-size instance for line-level timing, a shrunken instance
// for frame-level timing (screenEnd, vSync, active count, frame wrap, mid-frame reset).
module tb_vga_timing_generator;

  localparam int W = 640, H = 480, HF = 16, HS = 96, HB = 48;
  localparam int VF = 10, VS = 2, VB = 33;
  localparam int HT = W + HF + HS + HB;   // 800

  localparam int SW = 20, SH = 6, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVF = 2, SVS = 2, SVB = 2;
  localparam int SHT = SW + SHF + SHS + SHB;   // 28
  localparam int SVT = SH + SVF + SVS + SVB;   // 12
  localparam int SFRAME = SHT * SVT;           // 336

  logic       clk25 = 1'b0;
  logic       reset = 1'b1;
  logic       reset_s = 1'b1;
  logic       screenEnd, active, hSync, vSync;
  logic [9:0] x;
  logic [8:0] y;
  logic       screenEnd_s, active_s, hSync_s, vSync_s;
  logic [9:0] x_s;
  logic [8:0] y_s;

  int checks = 0;
  int passed = 0;

  always #20 clk25 = ~clk25;

  vga_timing_generator dut (
    .clk25(clk25), .reset(reset), .screenEnd(screenEnd), .active(active),
    .hSync(hSync), .vSync(vSync), .x(x), .y(y)
  );

  vga_timing_generator #(
    .WIDTH(SW), .HEIGHT(SH), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB)
  ) dut_s (
    .clk25(clk25), .reset(reset_s), .screenEnd(screenEnd_s), .active(active_s),
    .hSync(hSync_s), .vSync(vSync_s), .x(x_s), .y(y_s)
  );

  // Expected {screenEnd, active, hSync, vSync, x, y} for a counter position.
  function automatic logic [22:0] expv(int h, int v, int w, int ht, int hf, int hs,
                                       int vf, int vs);
    logic se, act, hsy, vsy;
    int xv, yv;
    se  = (h == 0) && (v == ht);
    act = (h < w) && (v < ht);
    hsy = !((h >= w + hf) && (h < w + hf + hs));
    vsy = !((v >= ht + vf) && (v < ht + vf + vs));
    xv  = (h < w) ? h : w - 1;
    yv  = (v < ht) ? v : ht - 1;
    return {se, act, hsy, vsy, 10'(xv), 9'(yv)};
  endfunction

  task automatic test_reset;
    logic [22:0] obs, exp_rst;
    exp_rst = {1'b0, 1'b1, 1'b1, 1'b1, 10'd0, 9'd0};
    reset = 1'b1;
    repeat (3) @(posedge clk25);
    @(negedge clk25);
    obs = {screenEnd, active, hSync, vSync, x, y};
    checks++;
    if (obs !== exp_rst) $display("FAIL reset_held: got %h expected %h", obs, exp_rst);
    else passed++;
    reset = 1'b0;
    // This negedge is cycle 0 after release: counters still at (0,0).
    checks++;
    if (obs !== exp_rst) $display("FAIL reset_first_cycle: got %h expected %h", obs, exp_rst);
    else passed++;
  endtask

  // Cycles 1..1700 after release: two full lines plus part of a third.
  task automatic test_line;
    logic [22:0] obs, e;
    int hs_low = 0, hs_first = -1, hs_last = -1, act_fall = -1;
    logic prev_act = 1'b1;
    for (int n = 1; n <= 1700; n++) begin
      @(negedge clk25);
      obs = {screenEnd, active, hSync, vSync, x, y};
      e = expv(n % HT, n / HT, W, H, HF, HS, VF, VS);
      checks++;
      if (obs !== e) $display("FAIL line_cycle%0d: got %h expected %h", n, obs, e);
      else passed++;
      if (n < HT) begin
        if (!hSync) begin
          hs_low++;
          if (hs_first < 0) hs_first = n;
          hs_last = n;
        end
        if (prev_act && !active && act_fall < 0) act_fall = n;
        prev_act = active;
      end
      if (n == 800) begin
        checks++;
        if (x !== 10'd0 || y !== 9'd1) $display("FAIL line_wrap: got x=%0d y=%0d expected x=0 y=1", x, y);
        else passed++;
      end
    end
    checks++;
    if (hs_low !== 96) $display("FAIL hsync_width: got %0d expected 96", hs_low);
    else passed++;
    checks++;
    if (hs_first !== 656 || hs_last !== 751)
      $display("FAIL hsync_window: got %0d..%0d expected 656..751", hs_first, hs_last);
    else passed++;
    checks++;
    if (act_fall !== 640) $display("FAIL active_fall: got %0d expected 640", act_fall);
    else passed++;
  endtask

  // Now at cycle 1700 (h=100, v=2); move to h=300 and pulse reset for one cycle.
  task automatic test_mid_line_reset;
    repeat (200) @(negedge clk25);
    checks++;
    if (x !== 10'd300 || y !== 9'd2) $display("FAIL midline_setup: got x=%0d y=%0d expected x=300 y=2", x, y);
    else passed++;
    reset = 1'b1;
    @(negedge clk25);
    reset = 1'b0;
    checks++;
    if ({x, y, active, screenEnd} !== {10'd0, 9'd0, 1'b1, 1'b0})
      $display("FAIL midline_reset: got x=%0d y=%0d active=%b screenEnd=%b expected 0 0 1 0", x, y, active, screenEnd);
    else passed++;
    @(negedge clk25);
    checks++;
    if (x !== 10'd1) $display("FAIL midline_resume: got x=%0d expected 1", x);
    else passed++;
  endtask

  // Small instance: two frames and a bit; screenEnd at 168 and 504 (SH*SHT, +SFRAME).
  task automatic test_frame_small;
    logic [22:0] obs, e;
    int se_cnt = 0, se_first = -1, se_second = -1, act_cnt = 0, vs_low = 0;
    int max_x = 0, max_y = 0;
    reset_s = 1'b1;
    @(negedge clk25);
    @(negedge clk25);
    reset_s = 1'b0;
    for (int n = 0; n < 2 * SFRAME + 6; n++) begin
      if (n > 0) @(negedge clk25);
      obs = {screenEnd_s, active_s, hSync_s, vSync_s, x_s, y_s};
      e = expv(n % SHT, (n / SHT) % SVT, SW, SH, SHF, SHS, SVF, SVS);
      checks++;
      if (obs !== e) $display("FAIL frame_cycle%0d: got %h expected %h", n, obs, e);
      else passed++;
      if (screenEnd_s) begin
        se_cnt++;
        if (se_first < 0) se_first = n;
        else if (se_second < 0) se_second = n;
      end
      if (n < SFRAME) begin
        if (active_s) act_cnt++;
        if (!vSync_s) vs_low++;
      end
      if (int'(x_s) > max_x) max_x = int'(x_s);
      if (int'(y_s) > max_y) max_y = int'(y_s);
      if (n == SFRAME) begin
        checks++;
        if ({x_s, y_s, active_s, screenEnd_s} !== {10'd0, 9'd0, 1'b1, 1'b0})
          $display("FAIL frame_wrap: got x=%0d y=%0d active=%b se=%b expected 0 0 1 0", x_s, y_s, active_s, screenEnd_s);
        else passed++;
      end
    end
    checks++;
    if (se_cnt !== 2) $display("FAIL screenend_count: got %0d expected 2", se_cnt);
    else passed++;
    checks++;
    if (se_first !== 168 || se_second !== 504)
      $display("FAIL screenend_pos: got %0d,%0d expected 168,504", se_first, se_second);
    else passed++;
    checks++;
    if (act_cnt !== 120) $display("FAIL active_count: got %0d expected 120", act_cnt);
    else passed++;
    checks++;
    if (vs_low !== 56) $display("FAIL vsync_width: got %0d expected 56", vs_low);
    else passed++;
    checks++;
    if (max_x !== 19 || max_y !== 5) $display("FAIL coord_saturate: got max x=%0d y=%0d expected 19 5", max_x, max_y);
    else passed++;
  endtask

  // Now at cycle 677; advance to 766 (h=10, v=3), reset one cycle, expect no early strobe.
  task automatic test_mid_frame_reset_small;
    int se_at = -1;
    repeat (89) @(negedge clk25);
    checks++;
    if (x_s !== 10'd10 || y_s !== 9'd3) $display("FAIL midframe_setup: got x=%0d y=%0d expected 10 3", x_s, y_s);
    else passed++;
    reset_s = 1'b1;
    @(negedge clk25);
    reset_s = 1'b0;
    checks++;
    if ({x_s, y_s, screenEnd_s} !== {10'd0, 9'd0, 1'b0})
      $display("FAIL midframe_reset: got x=%0d y=%0d se=%b expected 0 0 0", x_s, y_s, screenEnd_s);
    else passed++;
    for (int n = 1; n < 400 && se_at < 0; n++) begin
      @(negedge clk25);
      if (screenEnd_s) se_at = n;
    end
    checks++;
    if (se_at !== 168) $display("FAIL midframe_screenend: got %0d expected 168", se_at);
    else passed++;
  endtask

  initial begin
    test_reset;
    test_line;
    test_mid_line_reset;
    test_frame_small;
    test_mid_frame_reset_small;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
